// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// Latency: wires only; no storage.
// Backpressure: none of its own; stall/flush lines are the pipeline's hold/bubble controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard sources presented by the datapath
  logic [4:0]       id_rs1_index;
  logic [4:0]       id_rs2_index;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd_index;
  logic             ex_wb_en;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             dm_ready;
  logic             mem_halt;
  // pipeline register controls and status returned by the sequencer
  logic             pc_stall;
  logic             fd_stall;
  logic             fd_flush;
  logic             de_stall;
  logic             de_flush;
  logic             em_stall;
  logic             em_flush;
  logic             mw_flush;
  logic             halted;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline datapath side
  modport master (
    output id_rs1_index, id_rs2_index, id_use_rs1, id_use_rs2,
    output ex_rd_index, ex_wb_en, ex_is_load, ex_branch_taken,
    output mem_req, dm_ready, mem_halt,
    input  pc_stall, fd_stall, fd_flush, de_stall, de_flush,
    input  em_stall, em_flush, mw_flush, halted, timeout_err,
    input  stall_cnt, flush_cnt
  );

  // sequencer side
  modport slave (
    input  id_rs1_index, id_rs2_index, id_use_rs1, id_use_rs2,
    input  ex_rd_index, ex_wb_en, ex_is_load, ex_branch_taken,
    input  mem_req, dm_ready, mem_halt,
    output pc_stall, fd_stall, fd_flush, de_stall, de_flush,
    output em_stall, em_flush, mw_flush, halted, timeout_err,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubble, branch kill, dm wait freeze, halt drain.
// Latency: stall/flush outputs are combinational (0 cycles); halted, timeout_err and counters are registered.
// Backpressure: dm_ready low freezes PC..E/M and bubbles M/W until ready or MEM_TIMEOUT wait cycles.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic lu, run_eval, dm_stall, wait_expire;
  logic pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush;
  logic br_flush;

  // hazard decode; run_eval marks cycles where the normal RUN priority applies
  // (including the dm_ready cycle that ends a wait)
  always_comb begin
    lu = hz.ex_is_load & hz.ex_wb_en & (hz.ex_rd_index != 5'd0) &
         ((hz.id_use_rs1 & (hz.id_rs1_index == hz.ex_rd_index)) |
          (hz.id_use_rs2 & (hz.id_rs2_index == hz.ex_rd_index)));
    run_eval    = (state_q == RUN) | ((state_q == MEM_WAIT) & hz.dm_ready);
    dm_stall    = hz.mem_req & ~hz.dm_ready;
    wait_expire = (state_q == MEM_WAIT) & ~hz.dm_ready & (wait_q >= WAIT_LAST);
  end

  // state register and all other flops, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // next-state: halt beats memory wait; a pending halt waits for dm_ready
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (run_eval) begin
      if (hz.mem_halt) begin
        state_d = DRAIN;
      end else if (dm_stall) begin
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        MEM_WAIT: begin
          if (wait_expire) begin
            timeout_d = 1'b1;
            state_d   = HALTED;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        DRAIN:   state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = RUN;
      endcase
    end
    halted_d = (state_d == HALTED);
  end

  // stall/flush outputs; reset forces bubbles everywhere and no holds
  always_comb begin
    pc_stall = 1'b0; fd_stall = 1'b0; fd_flush = 1'b0; de_stall = 1'b0;
    de_flush = 1'b0; em_stall = 1'b0; em_flush = 1'b0; mw_flush = 1'b0;
    br_flush = 1'b0;
    if (reset) begin
      fd_flush = 1'b1; de_flush = 1'b1; em_flush = 1'b1; mw_flush = 1'b1;
    end else if (run_eval) begin
      if (hz.mem_halt) begin
        pc_stall = 1'b1; fd_flush = 1'b1; de_flush = 1'b1; em_flush = 1'b1;
      end else if (dm_stall) begin
        pc_stall = 1'b1; fd_stall = 1'b1; de_stall = 1'b1; em_stall = 1'b1; mw_flush = 1'b1;
      end else if (hz.ex_branch_taken) begin
        fd_flush = 1'b1; de_flush = 1'b1; br_flush = 1'b1;
      end else if (lu) begin
        pc_stall = 1'b1; fd_stall = 1'b1; de_flush = 1'b1;
      end
    end else begin
      case (state_q)
        MEM_WAIT, HALTED: begin
          pc_stall = 1'b1; fd_stall = 1'b1; de_stall = 1'b1; em_stall = 1'b1; mw_flush = 1'b1;
        end
        DRAIN: begin
          // M/W left alone so the halt instruction retires
          pc_stall = 1'b1; fd_flush = 1'b1; de_flush = 1'b1; em_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // saturating performance counters; stalls in HALTED are not counted
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (state_q != HALTED) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (br_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.fd_stall    = fd_stall;
  assign hz.fd_flush    = fd_flush;
  assign hz.de_stall    = de_stall;
  assign hz.de_flush    = de_flush;
  assign hz.em_stall    = em_stall;
  assign hz.em_flush    = em_flush;
  assign hz.mw_flush    = mw_flush;
  assign hz.halted      = halted_q;
  assign hz.timeout_err = timeout_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus multi-cycle sequences.
// Output vector order: {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush}.
// Counters run at 5 bits so saturation is reachable in a few dozen cycles.
module tb_pipe_hazard_ctrl;

  localparam int CW = 5;

  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_RST   = 8'h2B; // all flushes, no stalls
  localparam logic [7:0] O_LU    = 8'hC8; // pc_stall, fd_stall, de_flush
  localparam logic [7:0] O_BR    = 8'h28; // fd_flush, de_flush
  localparam logic [7:0] O_FRZ   = 8'hD5; // pc/fd/de/em stall, mw_flush
  localparam logic [7:0] O_DRAIN = 8'hAA; // pc_stall, fd/de/em flush

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       wb;
    logic       ld;
    logic       br;
    logic       mreq;
    logic       dmr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic use1, logic use2,
                              logic [4:0] rd, logic wb, logic ld, logic br, logic mreq, logic dmr,
                              logic [7:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd;
    v.wb = wb; v.ld = ld; v.br = br; v.mreq = mreq; v.dmr = dmr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {hz.pc_stall, hz.fd_stall, hz.fd_flush, hz.de_stall,
            hz.de_flush, hz.em_stall, hz.em_flush, hz.mw_flush};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    hz.id_rs1_index = 5'd0; hz.id_rs2_index = 5'd0;
    hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd_index = 5'd0; hz.ex_wb_en = 1'b0; hz.ex_is_load = 1'b0;
    hz.ex_branch_taken = 1'b0; hz.mem_req = 1'b0; hz.dm_ready = 1'b0; hz.mem_halt = 1'b0;
  endtask

  task automatic set_lu();
    hz.id_rs1_index = 5'd5; hz.id_use_rs1 = 1'b1;
    hz.ex_rd_index = 5'd5; hz.ex_wb_en = 1'b1; hz.ex_is_load = 1'b1;
  endtask

  task automatic apply(vec_t v);
    hz.id_rs1_index = v.rs1; hz.id_rs2_index = v.rs2;
    hz.id_use_rs1 = v.use1; hz.id_use_rs2 = v.use2;
    hz.ex_rd_index = v.rd; hz.ex_wb_en = v.wb; hz.ex_is_load = v.ld;
    hz.ex_branch_taken = v.br; hz.mem_req = v.mreq; hz.dm_ready = v.dmr; hz.mem_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int exp_stall;
    int exp_flush;
    checks = 0;
    errors = 0;

    //            name        rs1 rs2 u1 u2 rd  wb ld br mq dr exp
    vecs[0]  = mk("idle",      0,  0, 0, 0, 0,  0, 0, 0, 0, 0, O_NONE);
    vecs[1]  = mk("lu_rs1",    5,  0, 1, 0, 5,  1, 1, 0, 0, 0, O_LU);
    vecs[2]  = mk("lu_rd0",    0,  0, 1, 0, 0,  1, 1, 0, 0, 0, O_NONE);
    vecs[3]  = mk("lu_nouse",  5,  0, 0, 0, 5,  1, 1, 0, 0, 0, O_NONE);
    vecs[4]  = mk("lu_rs2",    1,  7, 0, 1, 7,  1, 1, 0, 0, 0, O_LU);
    vecs[5]  = mk("not_load",  5,  0, 1, 0, 5,  1, 0, 0, 0, 0, O_NONE);
    vecs[6]  = mk("no_wb",     5,  0, 1, 0, 5,  0, 1, 0, 0, 0, O_NONE);
    vecs[7]  = mk("br_lu",     5,  0, 1, 0, 5,  1, 1, 1, 0, 0, O_BR);
    vecs[8]  = mk("br_only",   0,  0, 0, 0, 0,  0, 0, 1, 0, 0, O_BR);
    vecs[9]  = mk("dm_hit",    0,  0, 0, 0, 0,  0, 0, 0, 1, 1, O_NONE);
    vecs[10] = mk("dm_hit_lu", 5,  0, 1, 0, 5,  1, 1, 0, 1, 1, O_LU);
    vecs[11] = mk("rd_miss",   5,  0, 1, 0, 6,  1, 1, 0, 0, 0, O_NONE);

    // reset with a live load-use hazard on the inputs: reset values must win
    reset = 1'b1;
    set_idle();
    set_lu();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", 32'(outs()), 32'(O_RST));
    chk("rst_halted", 32'(hz.halted), 32'd0);
    chk("rst_timeout", 32'(hz.timeout_err), 32'd0);
    chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    reset = 1'b0;
    set_idle();

    // RUN-state table; each vector lasts one cycle
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      exp_stall = exp_stall + int'(vecs[i].exp[7]);
      exp_flush = exp_flush + int'(vecs[i].exp[5]);
    end
    @(negedge clk);
    set_idle();
    #1;
    chk("tbl_idle_after", 32'(outs()), 32'(O_NONE));
    chk("tbl_stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));
    chk("tbl_flush_cnt", 32'(hz.flush_cnt), 32'(exp_flush));
    chk("tbl_halted", 32'(hz.halted), 32'd0);

    // three dm-wait cycles; a branch during the wait is ignored
    do_reset();
    @(negedge clk);
    hz.mem_req = 1'b1; hz.dm_ready = 1'b0;
    #1 chk("wait_c1", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.ex_branch_taken = 1'b1;
    #1 chk("wait_c2_br", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.ex_branch_taken = 1'b0;
    #1 chk("wait_c3", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.dm_ready = 1'b1;
    #1 chk("wait_release", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    set_idle();
    #1;
    chk("wait_stall_cnt", 32'(hz.stall_cnt), 32'd3);
    chk("wait_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    chk("wait_outs_after", 32'(outs()), 32'(O_NONE));

    // dm never ready: 16 wait cycles, then timeout + halted
    do_reset();
    @(negedge clk);
    hz.mem_req = 1'b1; hz.dm_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk($sformatf("to_wait%0d_outs", i), 32'(outs()), 32'(O_FRZ));
      chk($sformatf("to_wait%0d_halted", i), 32'(hz.halted), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("to_err", 32'(hz.timeout_err), 32'd1);
    chk("to_halted", 32'(hz.halted), 32'd1);
    chk("to_outs", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.mem_req = 1'b0; hz.dm_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_sticky", 32'(hz.timeout_err), 32'd1);
    chk("to_halted_sticky", 32'(hz.halted), 32'd1);
    chk("to_stall_cnt", 32'(hz.stall_cnt), 32'd16);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("to_rst_outs", 32'(outs()), 32'(O_RST));
    @(negedge clk);
    #1;
    chk("to_rst_err", 32'(hz.timeout_err), 32'd0);
    chk("to_rst_halted", 32'(hz.halted), 32'd0);
    reset = 1'b0;
    set_idle();

    // halt pulse: one drain cycle, then halted until reset
    do_reset();
    @(negedge clk);
    hz.mem_halt = 1'b1;
    #1 chk("halt_run", 32'(outs()), 32'(O_DRAIN));
    @(negedge clk);
    hz.mem_halt = 1'b0;
    #1;
    chk("halt_drain", 32'(outs()), 32'(O_DRAIN));
    chk("halt_drain_halted", 32'(hz.halted), 32'd0);
    @(negedge clk);
    set_lu();
    hz.ex_branch_taken = 1'b1;
    #1;
    chk("halt_state", 32'(outs()), 32'(O_FRZ));
    chk("halt_halted", 32'(hz.halted), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("halt_stay", 32'(hz.halted), 32'd1);
    chk("halt_stall_cnt", 32'(hz.stall_cnt), 32'd2);
    chk("halt_flush_cnt", 32'(hz.flush_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("halt_rst_outs", 32'(outs()), 32'(O_RST));
    @(negedge clk);
    #1;
    chk("halt_rst_halted", 32'(hz.halted), 32'd0);
    chk("halt_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
    reset = 1'b0;
    set_idle();
    #1 chk("halt_rst_run", 32'(outs()), 32'(O_NONE));

    // halt arriving mid-wait is held until dm_ready
    do_reset();
    @(negedge clk);
    hz.mem_req = 1'b1; hz.dm_ready = 1'b0;
    #1 chk("hw_wait", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.mem_halt = 1'b1;
    #1 chk("hw_held", 32'(outs()), 32'(O_FRZ));
    @(negedge clk);
    hz.dm_ready = 1'b1;
    #1 chk("hw_release", 32'(outs()), 32'(O_DRAIN));
    @(negedge clk);
    set_idle();
    #1 chk("hw_drain", 32'(outs()), 32'(O_DRAIN));
    @(negedge clk);
    #1 chk("hw_halted", 32'(hz.halted), 32'd1);

    // counter saturation
    do_reset();
    @(negedge clk);
    set_lu();
    repeat (40) @(negedge clk);
    #1 chk("sat_stall_cnt", 32'(hz.stall_cnt), 32'd31);
    set_idle();
    hz.ex_branch_taken = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("sat_flush_cnt", 32'(hz.flush_cnt), 32'd31);
    chk("sat_stall_hold", 32'(hz.stall_cnt), 32'd31);
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
